// File: rtl/ctrl_pkg.sv
// ============================================================
// ctrl_pkg : shared bus-select codes, opcodes and FSM encoding
// Rev 1.0  : initial release
// ============================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [3:0] SEL_DMEM = 4'd0;
  localparam logic [3:0] SEL_R    = 4'd1;
  localparam logic [3:0] SEL_IR   = 4'd2;
  localparam logic [3:0] SEL_RL   = 4'd3;
  localparam logic [3:0] SEL_RC   = 4'd4;
  localparam logic [3:0] SEL_RP   = 4'd5;
  localparam logic [3:0] SEL_RQ   = 4'd6;
  localparam logic [3:0] SEL_R1   = 4'd7;
  localparam logic [3:0] SEL_AC   = 4'd8;
  localparam logic [3:0] SEL_IDLE = 4'd9;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_END   = 8'h01;
  localparam logic [7:0] OP_LDAC  = 8'h02;
  localparam logic [7:0] OP_STAC  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_MUL   = 8'h22;
  localparam logic [7:0] OP_JMPNZ = 8'h30;
  localparam logic [4:0] OP_MVAC2X_HI = 5'b00010;
  localparam logic [4:0] OP_MVX2AC_HI = 5'b00011;

  localparam int WR_IR = 0;
  localparam int WR_AC = 7;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_MUL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Register index k (1..6) to its bus code; IR (code 2) sits between R and RL.
  function automatic logic [3:0] mvx_sel(input logic [2:0] k);
    return (k == 3'd1) ? SEL_R : ({1'b0, k} + 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================
// instr_decoder : state + IR -> control strobes and next state
// Rev 1.0       : initial release
// ============================================================
`default_nettype none

module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int INS_WIDTH = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic [2:0]           state,
  input  logic [INS_WIDTH-1:0] ir,
  input  logic                 start,
  input  logic                 zflag,
  output logic [2:0]           next_state,
  output logic [SEL_WIDTH-1:0] bus_sel,
  output logic [7:0]           wr_en,
  output logic [1:0]           alu_op,
  output logic                 imem_rd,
  output logic                 dmem_rd,
  output logic                 dmem_wr,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 done,
  output logic                 illegal
);

  logic [2:0] k;
  assign k = ir[2:0];

  always_comb begin
    next_state = state;
    bus_sel    = SEL_IDLE;
    wr_en      = '0;
    alu_op     = ALU_PASS;
    imem_rd    = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_t'(state))
      S_IDLE: if (start) next_state = S_FETCH1;
      S_FETCH1: begin
        imem_rd    = 1'b1;
        next_state = S_FETCH2;
      end
      S_FETCH2: begin
        wr_en[WR_IR] = 1'b1;
        pc_inc       = 1'b1;
        next_state   = S_EXEC1;
      end
      S_EXEC1: begin
        next_state = S_FETCH1;
        case (ir)
          OP_NOP: ;
          OP_END: next_state = S_HALT;
          OP_LDAC: begin
            dmem_rd    = 1'b1;
            next_state = S_EXEC2;
          end
          OP_STAC: begin
            bus_sel = SEL_AC;
            dmem_wr = 1'b1;
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            alu_op       = ir[1:0] + 2'd1;
            wr_en[WR_AC] = 1'b1;
          end
          OP_JMPNZ: begin
            imem_rd    = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_EXEC2;
          end
          default: begin
            // Register moves carry the register index in the low 3 bits; 0 and 7 are undefined.
            if (ir[7:3] == OP_MVAC2X_HI && k != 3'd0 && k != 3'd7) begin
              bus_sel  = SEL_AC;
              wr_en[k] = 1'b1;
            end else if (ir[7:3] == OP_MVX2AC_HI && k != 3'd0 && k != 3'd7) begin
              bus_sel      = mvx_sel(k);
              wr_en[WR_AC] = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
        endcase
      end
      S_EXEC2: begin
        next_state = S_FETCH1;
        if (ir == OP_LDAC) begin
          bus_sel      = SEL_DMEM;
          wr_en[WR_AC] = 1'b1;
        end else if (ir == OP_JMPNZ) begin
          pc_load = ~zflag;
        end
      end
      S_HALT: begin
        done = 1'b1;
        if (!start) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/core_control_unit.sv
// ============================================================
// core_control_unit : per-core fetch/decode/execute sequencer
// Rev 1.0           : initial release
// ============================================================
`default_nettype none

module core_control_unit
  import ctrl_pkg::*;
#(
  parameter int INS_WIDTH = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INS_WIDTH-1:0] iMemData,
  input  logic                 zFlag,
  output logic [SEL_WIDTH-1:0] busSel,
  output logic [7:0]           regWrEn,
  output logic [1:0]           aluOp,
  output logic                 iMemRd,
  output logic                 dMemRd,
  output logic                 dMemWrEn,
  output logic                 pcInc,
  output logic                 pcLoad,
  output logic                 done,
  output logic                 illegal
);

  state_t                 state;
  logic [INS_WIDTH-1:0]   ir;
  logic [2:0]             dec_next;
  logic [SEL_WIDTH-1:0]   dec_bus_sel;
  logic [7:0]             dec_wr_en;
  logic [1:0]             dec_alu_op;
  logic                   dec_imem_rd, dec_dmem_rd, dec_dmem_wr;
  logic                   dec_pc_inc, dec_pc_load, dec_done, dec_illegal;

  instr_decoder #(
    .INS_WIDTH (INS_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_decoder (
    .state      (state),
    .ir         (ir),
    .start      (start),
    .zflag      (zFlag),
    .next_state (dec_next),
    .bus_sel    (dec_bus_sel),
    .wr_en      (dec_wr_en),
    .alu_op     (dec_alu_op),
    .imem_rd    (dec_imem_rd),
    .dmem_rd    (dec_dmem_rd),
    .dmem_wr    (dec_dmem_wr),
    .pc_inc     (dec_pc_inc),
    .pc_load    (dec_pc_load),
    .done       (dec_done),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_t'(dec_next);
      if (state == S_FETCH2) ir <= iMemData;
    end
  end

  // Outputs are forced to idle while rst is high so an aborted instruction never fires a strobe.
  assign busSel   = rst ? SEL_IDLE : dec_bus_sel;
  assign regWrEn  = rst ? 8'h00    : dec_wr_en;
  assign aluOp    = rst ? ALU_PASS : dec_alu_op;
  assign iMemRd   = ~rst & dec_imem_rd;
  assign dMemRd   = ~rst & dec_dmem_rd;
  assign dMemWrEn = ~rst & dec_dmem_wr;
  assign pcInc    = ~rst & dec_pc_inc;
  assign pcLoad   = ~rst & dec_pc_load;
  assign done     = ~rst & dec_done;
  assign illegal  = ~rst & dec_illegal;

endmodule

`default_nettype wire

// File: tb/tb_core_control_unit.sv
// ============================================================
// tb_core_control_unit : scoreboard bench for core_control_unit
// Rev 1.0              : initial release
// ============================================================
`default_nettype none

module tb_core_control_unit;

  logic       clk = 1'b0;
  logic       rst, start, zFlag;
  logic [7:0] iMemData;
  logic [3:0] busSel;
  logic [7:0] regWrEn;
  logic [1:0] aluOp;
  logic       iMemRd, dMemRd, dMemWrEn, pcInc, pcLoad, done, illegal;

  // {busSel, regWrEn, aluOp, iMemRd, dMemRd, dMemWrEn, pcInc, pcLoad, done, illegal}
  localparam logic [6:0] IMEM = 7'b1000000;
  localparam logic [6:0] DRD  = 7'b0100000;
  localparam logic [6:0] DWR  = 7'b0010000;
  localparam logic [6:0] INC  = 7'b0001000;
  localparam logic [6:0] LOAD = 7'b0000100;
  localparam logic [6:0] DONE = 7'b0000010;
  localparam logic [6:0] ILL  = 7'b0000001;

  logic [20:0] exp_q[$];
  string       name_q[$];
  logic [20:0] got, expv;
  string       nm;
  int          checks = 0;
  int          failures = 0;
  logic        finished = 1'b0;

  core_control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .iMemData (iMemData),
    .zFlag    (zFlag),
    .busSel   (busSel),
    .regWrEn  (regWrEn),
    .aluOp    (aluOp),
    .iMemRd   (iMemRd),
    .dMemRd   (dMemRd),
    .dMemWrEn (dMemWrEn),
    .pcInc    (pcInc),
    .pcLoad   (pcLoad),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] ex(input logic [3:0] b, input logic [7:0] w,
                                     input logic [1:0] a, input logic [6:0] s);
    return {b, w, a, s};
  endfunction

  localparam logic [20:0] DFLT = {4'd9, 8'h00, 2'd0, 7'b0};

  // One cycle: queue what the DUT must show in the current cycle, then advance.
  task automatic cyc(input string n, input logic [20:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] op);
    cyc("fetch1", ex(4'd9, 8'h00, 2'd0, IMEM));
    iMemData = op;
    cyc("fetch2", ex(4'd9, 8'h01, 2'd0, INC));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {busSel, regWrEn, aluOp, iMemRd, dMemRd, dMemWrEn, pcInc, pcLoad, done, illegal};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", nm, got, expv);
      end
    end
  end

  initial begin
    #20000;
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; zFlag = 1'b0; iMemData = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (busSel !== 4'd9 || regWrEn !== 8'h00 || done !== 1'b0 || iMemRd !== 1'b0 ||
        pcInc !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busSel=%h regWrEn=%h done=%b iMemRd=%b pcInc=%b illegal=%b",
               busSel, regWrEn, done, iMemRd, pcInc, illegal);
    end
    cyc("reset0", DFLT);
    cyc("reset1", DFLT);
    rst = 1'b0;
    cyc("idle_start", DFLT);
    start = 1'b0;

    // Program {0x12, 0x01}
    fetch(8'h12);
    cyc("mvac2x_rl", ex(4'd8, 8'h04, 2'd0, 7'b0));
    fetch(8'h01);
    cyc("end_exec", DFLT);
    cyc("halt", ex(4'd9, 8'h00, 2'd0, DONE));
    start = 1'b1;
    cyc("idle_restart", DFLT);
    start = 1'b0;

    fetch(8'h02);
    cyc("ldac_e1", ex(4'd9, 8'h00, 2'd0, DRD));
    cyc("ldac_e2", ex(4'd0, 8'h80, 2'd0, 7'b0));
    fetch(8'h03);
    cyc("stac", ex(4'd8, 8'h00, 2'd0, DWR));
    fetch(8'h20);
    cyc("add", ex(4'd9, 8'h80, 2'd1, 7'b0));
    fetch(8'h21);
    cyc("sub", ex(4'd9, 8'h80, 2'd2, 7'b0));
    fetch(8'h22);
    cyc("mul", ex(4'd9, 8'h80, 2'd3, 7'b0));
    fetch(8'h19);
    cyc("mvx2ac_r", ex(4'd1, 8'h80, 2'd0, 7'b0));
    fetch(8'h1B);
    cyc("mvx2ac_rc", ex(4'd4, 8'h80, 2'd0, 7'b0));
    fetch(8'h1E);
    cyc("mvx2ac_r1", ex(4'd7, 8'h80, 2'd0, 7'b0));
    fetch(8'h16);
    cyc("mvac2x_r1", ex(4'd8, 8'h40, 2'd0, 7'b0));
    fetch(8'h11);
    cyc("mvac2x_r", ex(4'd8, 8'h02, 2'd0, 7'b0));

    fetch(8'h30);
    cyc("jmpnz_e1", ex(4'd9, 8'h00, 2'd0, IMEM | INC));
    iMemData = 8'h40; zFlag = 1'b0;
    cyc("jmpnz_taken", ex(4'd9, 8'h00, 2'd0, LOAD));
    fetch(8'h30);
    cyc("jmpnz_e1b", ex(4'd9, 8'h00, 2'd0, IMEM | INC));
    iMemData = 8'h40; zFlag = 1'b1;
    cyc("jmpnz_not_taken", DFLT);
    zFlag = 1'b0;

    fetch(8'hFF);
    cyc("illegal_ff", ex(4'd9, 8'h00, 2'd0, ILL));
    fetch(8'h17);
    cyc("illegal_17", ex(4'd9, 8'h00, 2'd0, ILL));
    fetch(8'h00);
    cyc("nop", DFLT);

    // Reset during LDAC EXEC2 must suppress the AC write
    fetch(8'h02);
    cyc("ldac_e1_pre_rst", ex(4'd9, 8'h00, 2'd0, DRD));
    rst = 1'b1;
    cyc("rst_in_ldac_e2", DFLT);
    rst = 1'b0;
    cyc("after_rst_idle", DFLT);
    cyc("idle_hold", DFLT);
    start = 1'b1;
    cyc("idle_start2", DFLT);

    // HALT is held while start stays high
    fetch(8'h01);
    cyc("end_exec2", DFLT);
    cyc("halt_hold0", ex(4'd9, 8'h00, 2'd0, DONE));
    cyc("halt_hold1", ex(4'd9, 8'h00, 2'd0, DONE));
    start = 1'b0;
    cyc("halt_release", ex(4'd9, 8'h00, 2'd0, DONE));
    cyc("idle_final", DFLT);

    @(posedge clk); #1;
    finished = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
